sw_debounce_bank: RTL

SW_DEBOUNCE_BANK -- requirements
Module: sw_debounce_bank

---
 rtl/sw_debounce_bank_if.sv | 21 ++
 rtl/sw_debounce_bank.sv | 76 +++++++
 2 files changed

// File: rtl/sw_debounce_bank_if.sv
// Debounced switch bank signal bundle: raw levels in, clean levels/edges/toggles out.
interface sw_debounce_bank_if #(
  parameter int N = 8
);
  logic [N-1:0] sw_in;
  logic [N-1:0] sw_level;
  logic [N-1:0] sw_rise;
  logic [N-1:0] sw_fall;
  logic [N-1:0] sw_toggle;
  logic         any_change;

  modport master (
    output sw_in,
    input  sw_level, sw_rise, sw_fall, sw_toggle, any_change
  );

  modport slave (
    input  sw_in,
    output sw_level, sw_rise, sw_fall, sw_toggle, any_change
  );
endinterface

// File: rtl/sw_debounce_bank.sv
// Per-channel 2-flop sync + debounce counter; level/pulse/toggle appear 2+DEBOUNCE_CYCLES edges after a held change.
// No backpressure: switch inputs are sampled every cycle and all outputs are registered.
module sw_debounce_bank #(
  parameter int N               = 8,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic              clk,
  input  logic              rst,
  sw_debounce_bank_if.slave bus
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [N-1:0]  r_s1;
  logic [N-1:0]  r_s2;
  logic [N-1:0]  r_stable;
  logic [N-1:0]  r_rise;
  logic [N-1:0]  r_fall;
  logic [N-1:0]  r_toggle;
  logic          r_any;
  logic [CW-1:0] r_cnt [N];

  logic [N-1:0]  w_diff;
  logic [N-1:0]  w_accept;
  logic [N-1:0]  w_rise;
  logic [N-1:0]  w_fall;

  // A channel accepts its new level on the edge that would push the count past its limit.
  always_comb begin
    w_diff   = r_s2 ^ r_stable;
    w_accept = '0;
    for (int i = 0; i < N; i++) begin
      w_accept[i] = w_diff[i] && (r_cnt[i] == CNT_MAX);
    end
    w_rise = w_accept & r_s2;
    w_fall = w_accept & ~r_s2;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1     <= '0;
      r_s2     <= '0;
      r_stable <= '0;
      r_rise   <= '0;
      r_fall   <= '0;
      r_toggle <= '0;
      r_any    <= 1'b0;
      for (int i = 0; i < N; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_s1     <= bus.sw_in;
      r_s2     <= r_s1;
      r_stable <= r_stable ^ w_accept;
      r_rise   <= w_rise;
      r_fall   <= w_fall;
      r_toggle <= r_toggle ^ w_rise;
      r_any    <= |(w_rise | w_fall);
      for (int i = 0; i < N; i++) begin
        if (!w_diff[i] || w_accept[i]) begin
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign bus.sw_level   = r_stable;
  assign bus.sw_rise    = r_rise;
  assign bus.sw_fall    = r_fall;
  assign bus.sw_toggle  = r_toggle;
  assign bus.any_change = r_any;

endmodule
